// File: rtl/param_ram_defs.sv
// param_ram_defs: shared FSM encodings, latency check and sizing helpers for param_ram.

// True when the read latency parameter is one of the supported values.
`define PARAM_RAM_LATENCY_OK(lat) (((lat) == 1) || ((lat) == 2))

package param_ram_defs;

  // Controller states: CLEAR zeroes the array, RUN serves requests.
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam int unsigned BYTE_W = 8;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((64'd1 << r) < 64'(value))) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Array index width; never narrower than one bit so a single-word RAM still has an index.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (clog2(depth) == 0) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/param_ram_out_pipe.sv
// param_ram_out_pipe: one extra falling-edge register stage for the read response.

module param_ram_out_pipe
  import param_ram_defs::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] stage_data,
  input  logic                  stage_valid,
  input  logic                  stage_error,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  addr_error
);

  // Delay the whole response by one falling edge; reset discards anything in flight.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      data_out   <= stage_data;
      data_valid <= stage_valid;
      addr_error <= stage_error;
    end
  end

endmodule

// File: rtl/param_ram.sv
// param_ram: single-port falling-edge RAM with byte enables, range checking,
// selectable read latency and a post-reset clear sequence.

module param_ram
  import param_ram_defs::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned DEPTH          = 64,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    chip_select,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    addr_error,
  output logic                    ready
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_W;
  localparam int unsigned IDX_W     = idx_width(DEPTH);

  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [0:0]          RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  // Elaboration-time parameter legality.
  if (!`PARAM_RAM_LATENCY_OK(READ_LATENCY)) begin : g_bad_latency
    $error("param_ram: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH == 0) begin : g_bad_width
    $error("param_ram: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH == 0 || clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_depth
    $error("param_ram: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH");
  end

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [IDX_W-1:0]      clr_ptr;
  logic [IDX_W-1:0]      clr_ptr_next;
  logic                  clr_we;

  logic                  accept;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;
  logic                  s1_err;

  // Controller state, clear pointer and registered ready.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state   <= RESET_STATE;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
      ready   <= (state_next == ST_RUN);
    end
  end

  // Next state: walk the clear pointer across every word, then hand over to RUN.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    clr_we       = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_ptr == LAST_IDX) begin
          state_next = ST_RUN;
        end else begin
          clr_ptr_next = clr_ptr + IDX_W'(1);
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // Request decode; ready is only high in RUN, so clear and user writes never collide.
  assign accept   = chip_select & ready;
  assign in_range = ({1'b0, address} < DEPTH_LIMIT);
  assign idx      = address[IDX_W-1:0];
  assign wr_en    = accept & we & in_range;
  assign rd_en    = accept & ~we & in_range;

  // Array update: one cleared word per edge during CLEAR, otherwise a byte-masked write.
  always_ff @(negedge clock) begin
    if (clr_we) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
        if (byte_en[b]) begin
          mem[idx][b*BYTE_W +: BYTE_W] <= data_in[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // First response stage: read word (zero if out of range) and strobes on the accepting edge.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_data  <= rd_en ? mem[idx] : '0;
      s1_valid <= accept & ~we;
      s1_err   <= accept & ~in_range;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    param_ram_out_pipe #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_out_pipe (
      .clock       (clock),
      .reset       (reset),
      .stage_data  (s1_data),
      .stage_valid (s1_valid),
      .stage_error (s1_err),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .addr_error  (addr_error)
    );
  end else begin : g_lat1
    assign data_out   = s1_data;
    assign data_valid = s1_valid;
    assign addr_error = s1_err;
  end

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: randomized scoreboard bench driving a latency-1 and a latency-2 param_ram in lockstep.

module tb_param_ram;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned NB    = DW / 8;

  logic          clock       = 1'b0;
  logic          reset       = 1'b1;
  logic          chip_select = 1'b0;
  logic          we          = 1'b0;
  logic [NB-1:0] byte_en     = '0;
  logic [AW-1:0] address     = '0;
  logic [DW-1:0] data_in     = '0;

  logic [DW-1:0] do1, do2;
  logic          dv1, dv2, ae1, ae2, rdy1, rdy2;

  always #5 clock = ~clock;

  param_ram #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEPTH),
    .READ_LATENCY (1), .CLEAR_ON_RESET (1'b1)
  ) u_lat1 (
    .clock (clock), .reset (reset), .chip_select (chip_select), .we (we),
    .byte_en (byte_en), .address (address), .data_in (data_in),
    .data_out (do1), .data_valid (dv1), .addr_error (ae1), .ready (rdy1)
  );

  param_ram #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEPTH),
    .READ_LATENCY (2), .CLEAR_ON_RESET (1'b1)
  ) u_lat2 (
    .clock (clock), .reset (reset), .chip_select (chip_select), .we (we),
    .byte_en (byte_en), .address (address), .data_in (data_in),
    .data_out (do2), .data_valid (dv2), .addr_error (ae2), .ready (rdy2)
  );

  // Expected response: the falling-edge number after which it must be visible.
  typedef struct {
    int unsigned   due;
    logic          valid;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q1[$];
  exp_t          q2[$];
  logic [DW-1:0] mem_m [DEPTH];
  int unsigned   edge_no   = 0;
  int unsigned   rel_edge  = 0;
  int            n_cmp     = 0;
  int            n_bad     = 0;

  always @(negedge clock) edge_no++;

  task automatic compare(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Monitor for one DUT: ready vs. clear timing, and response vs. scoreboard head.
  task automatic check_port(input int which, input logic v, input logic e,
                            input logic [DW-1:0] d, input logic rdy);
    exp_t  x;
    bit    have;
    bit    exp_rdy;
    string p;
    p = (which == 1) ? "lat1" : "lat2";
    exp_rdy = !reset && ((edge_no - rel_edge) >= DEPTH);
    compare({p, " ready"}, DW'(rdy), DW'(exp_rdy));
    have = 1'b0;
    if (which == 1 && q1.size() > 0) begin x = q1[0]; have = 1'b1; end
    if (which == 2 && q2.size() > 0) begin x = q2[0]; have = 1'b1; end
    if (have && x.due == edge_no) begin
      compare({p, " data_valid"}, DW'(v), DW'(x.valid));
      compare({p, " addr_error"}, DW'(e), DW'(x.err));
      compare({p, " data_out"}, d, x.data);
      if (which == 1) void'(q1.pop_front());
      else            void'(q2.pop_front());
    end else begin
      compare({p, " idle data_valid"}, DW'(v), '0);
      compare({p, " idle addr_error"}, DW'(e), '0);
      compare({p, " idle data_out"}, d, '0);
    end
  endtask

  always @(negedge clock) begin
    #2;
    check_port(1, dv1, ae1, do1, rdy1);
    check_port(2, dv2, ae2, do2, rdy2);
  end

  // Drive one request half a cycle before the falling edge and predict its response.
  task automatic issue(input logic cs_i, input logic we_i, input logic [NB-1:0] be_i,
                       input logic [AW-1:0] a_i, input logic [DW-1:0] d_i);
    exp_t x;
    bit   acc;
    bit   inr;
    @(posedge clock);
    chip_select = cs_i;
    we          = we_i;
    byte_en     = be_i;
    address     = a_i;
    data_in     = d_i;
    acc = cs_i && !reset && ((edge_no - rel_edge) >= DEPTH);
    inr = int'(a_i) < int'(DEPTH);
    if (acc) begin
      if (we_i && inr) begin
        for (int b = 0; b < int'(NB); b++) begin
          if (be_i[b]) mem_m[a_i[5:0]][8*b +: 8] = d_i[8*b +: 8];
        end
      end
      if (!we_i || !inr) begin
        x.valid = !we_i;
        x.err   = !inr;
        x.data  = (!we_i && inr) ? mem_m[a_i[5:0]] : '0;
        x.due   = edge_no + 1;
        q1.push_back(x);
        x.due   = edge_no + 2;
        q2.push_back(x);
      end
    end
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    issue(1'b1, 1'b1, be, a, d);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    issue(1'b1, 1'b0, '0, a, '0);
  endtask

  // Assert reset; anything in flight is dropped, and the clear leaves all words zero.
  task automatic do_reset(input int hold);
    @(posedge clock);
    reset       = 1'b1;
    chip_select = 1'b0;
    q1.delete();
    q2.delete();
    repeat (hold) @(posedge clock);
    reset    = 1'b0;
    rel_edge = edge_no;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
  endtask

  task automatic wait_ready();
    while ((edge_no - rel_edge) < DEPTH) idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;

    do_reset(3);
    wait_ready();

    // Every word reads back zero after the clear, back to back.
    for (int i = 0; i < int'(DEPTH); i++) rd(AW'(i));

    // Byte enables: partial write merges into the full-word write.
    wr(AW'(5), 4'b1111, 32'hAABBCCDD);
    wr(AW'(5), 4'b0101, 32'h11223344);
    rd(AW'(5));
    wr(AW'(5), 4'b0000, 32'hFFFFFFFF);
    rd(AW'(5));
    idle();

    // Write followed immediately by a read of the same word.
    wr(AW'(3), 4'b1111, 32'hDEADBEEF);
    rd(AW'(3));
    idle();
    idle();

    // Range check: write and read beyond the array, then confirm word 0 untouched.
    wr(AW'(64), 4'b1111, 32'h12345678);
    rd(AW'(64));
    rd(AW'(0));
    rd(AW'(2047));
    idle();

    // Throughput: preload words 0..7, then eight consecutive reads.
    for (int i = 0; i < 8; i++) wr(AW'(i), 4'b1111, DW'(i + 1));
    for (int i = 0; i < 8; i++) rd(AW'(i));
    idle();

    // Randomized mix of reads, writes, masks, idle cycles and out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) a = AW'($urandom);
      else                           a = AW'($urandom_range(0, DEPTH + 5));
      issue(($urandom_range(0, 7) != 0), 1'($urandom), NB'($urandom), a, $urandom);
    end

    // Reset right after a read is accepted: the latency-2 response must never appear.
    rd(AW'(1));
    do_reset(2);

    // Reset again at clear word 30; the clear must restart and take the full depth.
    while ((edge_no - rel_edge) < 30) idle();
    do_reset(2);

    // Requests during the clear are dropped: no write, no error strobe.
    while ((edge_no - rel_edge) < 40) idle();
    wr(AW'(2), 4'b1111, 32'hCAFEF00D);
    wr(AW'(100), 4'b1111, 32'h0BADF00D);
    rd(AW'(2));
    wait_ready();
    rd(AW'(2));
    rd(AW'(63));
    wr(AW'(63), 4'b1000, 32'h5A000000);
    rd(AW'(63));

    repeat (4) idle();
    compare("lat1 queue drained", DW'(q1.size()), '0);
    compare("lat2 queue drained", DW'(q2.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
